// File: rtl/dfr_readout.sv
// Weighted linear readout over one frame of reservoir virtual-node samples.
// Emits a saturated Q-format result one cycle after the last sample of each frame.
module dfr_readout #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 16,
  parameter int ACC_WIDTH     = 2*DATA_WIDTH+8,
  localparam int AW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  sof,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_sat,
  output logic                  busy
);

  // state   | meaning
  // S_IDLE  | node index 0, accumulator clear, waiting for sample 0
  // S_ACCUM | partial frame held, 0 < node index < VIRTUAL_NODES
  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        w_q [VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]        w_d [VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]        dout_q, dout_d;
  logic                         valid_q, valid_d;
  logic                         sat_q, sat_d;

  logic                         start;
  logic                         last;
  logic [AW-1:0]                rd_idx;
  logic [DATA_WIDTH-1:0]        w_sel;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;

  always_comb begin
    start  = din_valid & sof;
    rd_idx = start ? '0 : idx_q;
    w_sel  = '0;
    for (int i = 0; i < VIRTUAL_NODES; i++) begin
      if (rd_idx == AW'(i)) w_sel = w_q[i];
    end
    prod    = $signed(din) * $signed(w_sel);
    sum     = (start ? '0 : acc_q)
              + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    shifted = sum >>> FRAC_BITS;
    hi      = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    last    = din_valid && (rd_idx == AW'(VIRTUAL_NODES-1));
  end

  always_comb begin
    idx_d   = idx_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    for (int i = 0; i < VIRTUAL_NODES; i++) begin
      w_d[i] = w_q[i];
      if (w_we && w_addr == AW'(i)) w_d[i] = w_data;
    end
    if (din_valid) begin
      acc_d = sum;
      idx_d = rd_idx + AW'(1);
    end
    if (last) begin
      acc_d   = '0;
      idx_d   = '0;
      valid_d = 1'b1;
      // In range only when every bit above the result's sign bit matches it.
      if ((&hi) || !(|hi)) begin
        dout_d = shifted[DATA_WIDTH-1:0];
        sat_d  = 1'b0;
      end else begin
        dout_d = hi[ACC_WIDTH-DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        sat_d  = 1'b1;
      end
    end
    state_d = (idx_d != '0) ? S_ACCUM : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < VIRTUAL_NODES; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      for (int i = 0; i < VIRTUAL_NODES; i++) w_q[i] <= w_d[i];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_sat   = sat_q;
  assign busy       = (state_q == S_ACCUM);

endmodule

// File: tb/tb_dfr_readout.sv
// Scoreboard bench for dfr_readout: driver feeds a frame-level reference model,
// a negedge monitor pops expected results whenever the DUT strobes.
module tb_dfr_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid, sof, w_we;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] dout;
  logic        dout_valid, dout_sat, busy;

  dfr_readout dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .dout(dout),
    .dout_valid(dout_valid), .dout_sat(dout_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic s; int due;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int negcnt = 0;

  logic [31:0]        wm [10];
  logic signed [95:0] pq [$];
  logic [31:0]        last_d = '0;
  logic               last_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: each accepted sample contributes din*W[position in frame];
  // the frame result is the floor-shifted exact sum clipped to 32-bit signed.
  task automatic model_accept(input logic [31:0] d, input bit sf);
    logic signed [95:0] a, b, s;
    exp_t e;
    if (sf) pq.delete();
    a = {{64{d[31]}}, d};
    b = {{64{wm[pq.size()][31]}}, wm[pq.size()]};
    pq.push_back(a * b);
    if (pq.size() == 10) begin
      s = '0;
      foreach (pq[k]) s = s + pq[k];
      s = s >>> 16;
      if (s > 96'sd2147483647) begin
        e.d = 32'h7FFF_FFFF; e.s = 1'b1;
      end else if (s < -96'sd2147483648) begin
        e.d = 32'h8000_0000; e.s = 1'b1;
      end else begin
        e.d = s[31:0]; e.s = 1'b0;
      end
      e.due = negcnt + 1;
      sb.push_back(e);
      pq.delete();
    end
  endtask

  task automatic drive(input bit dv, input bit sf, input logic [31:0] d,
                       input bit we, input logic [3:0] a, input logic [31:0] wd);
    din_valid = dv; sof = sf; din = d; w_we = we; w_addr = a; w_data = wd;
    @(posedge clk);
    if (dv) model_accept(d, sf);
    if (we && a < 4'd10) wm[a] = wd;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, pq.size() != 0});
    @(negedge clk);
    din_valid = 1'b0; sof = 1'b0; w_we = 1'b0;
  endtask

  task automatic set_all_w(input logic [31:0] v);
    for (int i = 0; i < 10; i++) drive(0, 0, '0, 1, 4'(i), v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    negcnt++;
    if (rst) begin
      if (dout_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_strobe", {31'd0, dout_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("dout", dout, e.d);
          chk("dout_sat", {31'd0, dout_sat}, {31'd0, e.s});
          chk("strobe_cycle", negcnt, e.due);
          last_d = e.d;
          last_s = e.s;
        end
      end else begin
        chk("dout_hold", dout, last_d);
        chk("sat_hold", {31'd0, dout_sat}, {31'd0, last_s});
        if (sb.size() > 0 && sb[0].due < negcnt) begin
          chk("strobe_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] d, wv;
    rst = 1'b0; din = '0; din_valid = 0; sof = 0; w_we = 0; w_addr = '0; w_data = '0;
    for (int i = 0; i < 10; i++) wm[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_sat", {31'd0, dout_sat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    set_all_w(32'h0001_0000);
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h0001_0000, 0, '0, '0);
    repeat (2) drive(0, 0, '0, 0, '0, '0);

    set_all_w(32'h0);
    drive(0, 0, '0, 1, 4'd3, 32'hFFFF_0000);
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h0002_0000, 0, '0, '0);

    set_all_w(32'h7FFF_FFFF);
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h7FFF_FFFF, 0, '0, '0);
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h8000_0000, 0, '0, '0);

    set_all_w(32'h0001_0000);
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h0005_0000, 0, '0, '0);
    for (int i = 0; i < 10; i++) drive(1, i == 0, 32'h0001_0000, 0, '0, '0);
    drive(0, 0, '0, 0, '0, '0);

    for (int i = 0; i < 20; i++) drive(1, 0, 32'(i) * 32'h028F_5C29, 0, '0, '0);
    drive(0, 0, '0, 0, '0, '0);

    // Write to the node being read this cycle must use the old weight.
    drive(1, 0, 32'h0003_0000, 1, 4'd0, 32'h0002_0000);
    drive(1, 0, 32'h0001_0000, 1, 4'd12, 32'h1234_5678);
    for (int i = 2; i < 10; i++) drive(1, 0, 32'h0001_0000, 0, '0, '0);
    drive(0, 0, '0, 0, '0, '0);

    for (int i = 0; i < 6; i++) drive(1, 0, 32'h0001_0000, 0, '0, '0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dout", dout, 32'd0);
    chk("async_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("async_rst_sat", {31'd0, dout_sat}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) wm[i] = '0;
    pq.delete();
    last_d = '0; last_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) drive(1, 0, 32'h0007_0000, 0, '0, '0);
    drive(0, 0, '0, 0, '0, '0);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = 0;
      while (n < 10) begin
        bit dv, sf, we;
        dv = ($urandom_range(0, 9) < 8);
        sf = dv && ($urandom_range(0, 19) == 0);
        we = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) d = $urandom;
        else d = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
        if ($urandom_range(0, 3) == 0) wv = $urandom;
        else wv = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
        drive(dv, sf, d, we, 4'($urandom_range(0, 15)), wv);
        if (dv) n = sf ? 1 : n + 1;
      end
    end

    repeat (4) drive(0, 0, '0, 0, '0, '0);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
